dds_carrier: RTL and testbench
==============================

# dds_carrier

Phase-accumulator carrier generator feeding the carrier input of the AM multiplier stage. Produces a 12-bit offset-binary sine (midpoint 2047) from a 32-bit frequency word through a quarter-wave sine ROM. It supports glitch-free frequency updates aligned to carrier cycle boundaries, a phase-clear input, and a cycle-start strobe for downstream framing.

## Interface
- PHASE_W, 32, phase accumulator width
- Q_ADDR_W, 10, quarter-wave ROM address width (ROM depth 2^Q_ADDR_W)
- FW_RESET, 32'd0, frequency word loaded at reset
- LUT_FILE, "sine_q.hex", ROM init file: entry i = round(2047·sin((2i+1)·π/2^(Q_ADDR_W+2))), 11-bit unsigned
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  accumulator advance enable
- sync_clr  in  1  clear phase to 0, apply any pending frequency word
- fw_data  in  PHASE_W  new frequency word
- fw_valid  in  1  fw_data valid
- fw_ready  out  1  pending slot empty; transfer on fw_valid & fw_ready
- dac_car  out  12  carrier sample, offset binary, range 0..4094
- car_valid  out  1  dac_car derived from an enabled phase step
- wrap  out  1  one-cycle strobe, aligned with first sample of each new carrier cycle

## Operation
- Registers: phase P, active word FW, pending word FWP, pending flag.
- Each cycle with en=1: {carry, P} <= P + FW (mod 2^PHASE_W). en=0: P holds.
- Handshake: on fw_valid & fw_ready, FWP <= fw_data, pending <= 1, fw_ready <= 0 next cycle.
- Apply: in a cycle with en=1, carry=1 and pending=1: FW <= FWP, pending <= 0. The accumulator step in that cycle still uses the old FW; the new FW is used from the next step. A transfer accepted in the same cycle as a carry is not applied until the next carry.
- sync_clr=1 (has priority over en): P <= 0; if pending, FW <= FWP and pending <= 0; a simultaneous fw transfer is accepted and stays pending. sync_clr counts as a cycle start (generates wrap).
- Stage 1: q = P[PHASE_W-1:PHASE_W-2], idx = P[PHASE_W-3 -: Q_ADDR_W]; addr = q[0] ? ~idx : idx; register addr, q, start flag, en flag.
- Stage 2: mag <= rom[addr] (synchronous read); pipeline q, flags.
- Stage 3: dac_car <= q[1] ? 2047 − mag : 2047 + mag; car_valid <= en flag; wrap <= start flag.
- Arithmetic: 12-bit unsigned. Since mag ≤ 2047, no overflow or underflow occurs. The output never equals 2047 exactly, because the half-sample ROM offset is intentional.
- The pipeline always flows. With en=0, dac_car settles to the held phase value and car_valid drops.

## Timing
- Reset values (next edge with rst=1): P=0, FW=FW_RESET, pending=0, fw_ready=1, dac_car=2047, car_valid=0, wrap=0, all pipeline flags cleared.
- Reset mid-operation discards the pending word and all in-flight samples. The first valid output appears 3 cycles after the first enabled cycle following reset.
- Latency: a phase value registered in P at edge k appears on dac_car at edge k+3.
- wrap is high exactly on the dac_car sample computed from the first P after a carry or sync_clr.
- fw_ready returns to 1 the cycle after the word is applied. At most one word is pending.
- Throughput: one sample per clk while en=1.

## Test plan
- Reset: hold rst 3 cycles with en=1 → dac_car=2047, car_valid=0, wrap=0, fw_ready=1 throughout; release → car_valid rises 3 cycles after the first enabled edge.
- FW_RESET=2^30, en=1 → dac_car repeats 2049, 4094, 2045, 0; wrap is high on each 2049 sample; car_valid stays at 1.
- Deferred update: running at FW=2^30, send fw_data=2^29 mid-cycle → fw_ready=0 until the next carry; the sample period doubles (8 samples/cycle) from the step after the carry; no phase jump.
- Transfer coincident with carry: fw_valid asserted in a carry cycle → word held pending for a full extra carrier cycle, then applied.
- en low for 5 cycles mid-cycle → dac_car holds its last value, car_valid=0 for 5 samples (after 3-cycle lag); P resumes without a skip.
- sync_clr with a pending word → P=0, new FW active immediately, fw_ready=1 the next cycle, wrap strobe 3 cycles later with dac_car=2049 (FW=2^30 case).

Source files
------------

// File: rtl/dds_carrier.sv
// dds_carrier: phase-accumulator carrier generator with a quarter-wave sine ROM.
// Produces a 12-bit offset-binary sine (midpoint 2047). Frequency updates are
// deferred to the next carrier cycle boundary, so the phase never jumps.
// The ROM content is built at elaboration from the same formula used to
// produce sine_q.hex: entry i = round(2047*sin((2i+1)*pi/2^(Q_ADDR_W+2))).

module dds_carrier #(
  parameter int unsigned        PHASE_W  = 32,
  parameter int unsigned        Q_ADDR_W = 10,
  parameter logic [PHASE_W-1:0] FW_RESET = 32'd0,
  parameter                     LUT_FILE = "sine_q.hex"
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync_clr,
  input  logic [PHASE_W-1:0] fw_data,
  input  logic               fw_valid,
  output logic               fw_ready,
  output logic [11:0]        dac_car,
  output logic               car_valid,
  output logic               wrap
);

  localparam int unsigned         MAG_W  = 11;
  localparam int unsigned         DEPTH  = 32'd1 << Q_ADDR_W;
  localparam logic [11:0]         MID    = 12'd2047;
  // pi scaled by 2^60 (hex expansion of pi)
  localparam logic signed [127:0] PI_Q60 = 128'sh3243_F6A8_885A_308D;

  // Quarter-wave table entry, Taylor series in Q60 fixed point, rounded to nearest.
  function automatic logic [MAG_W-1:0] sine_entry(input int idx);
    logic signed [127:0] x_v, x2_v, term_v, sum_v, div_v, scaled_v;
    x_v    = $signed((128'(32'sd2 * idx + 32'sd1) * PI_Q60) >>> (Q_ADDR_W + 32'd2));
    x2_v   = (x_v * x_v) >>> 32'd60;
    term_v = x_v;
    sum_v  = x_v;
    for (int n = 1; n <= 13; n++) begin
      div_v  = 128'(32'sd2 * n * (32'sd2 * n + 32'sd1));
      term_v = -(((term_v * x2_v) >>> 32'd60) / div_v);
      sum_v  = sum_v + term_v;
    end
    scaled_v = (sum_v * 128'sd2047 + (128'sd1 <<< 32'd59)) >>> 32'd60;
    return scaled_v[MAG_W-1:0];
  endfunction

  // Only the built-in table is available; reject any other table name at elaboration.
  if (LUT_FILE != "sine_q.hex") begin : g_lut_check
    $error("dds_carrier: only the built-in quarter-wave table (sine_q.hex) is supported");
  end

  logic [MAG_W-1:0] rom_s [DEPTH];
  for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_rom
    localparam logic [MAG_W-1:0] ENTRY = sine_entry(gi);
    assign rom_s[gi] = ENTRY;
  end

  // Accumulator / frequency-word state
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] fw_q, fw_d;
  logic [PHASE_W-1:0] fwp_q, fwp_d;
  logic               pend_q, pend_d;
  logic               rdy_q, rdy_d;
  logic               start_q, start_d;   // phase_q is the first of a new cycle
  logic               step_q, step_d;     // phase_q came from an enabled step
  logic [PHASE_W:0]   sum_s;
  logic               accept_s;

  // Pipeline stages
  logic [Q_ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic [1:0]          s1_quad_q, s1_quad_d;
  logic                s1_start_q, s1_vld_q;
  logic [MAG_W-1:0]    s2_mag_q, s2_mag_d;
  logic [1:0]          s2_quad_q;
  logic                s2_start_q, s2_vld_q;
  logic [11:0]         dac_q, dac_d;
  logic                car_vld_q, wrap_q;
  logic [Q_ADDR_W-1:0] idx_s;

  // Next-state for phase, active/pending words and the handshake.
  always_comb begin
    sum_s    = {1'b0, phase_q} + {1'b0, fw_q};
    accept_s = fw_valid & rdy_q;
    phase_d  = phase_q;
    fw_d     = fw_q;
    fwp_d    = fwp_q;
    pend_d   = pend_q;
    start_d  = 1'b0;
    step_d   = en;
    if (sync_clr) begin
      phase_d = '0;
      start_d = 1'b1;
      if (pend_q) begin
        fw_d   = fwp_q;
        pend_d = 1'b0;
      end else begin
        fw_d   = fw_q;
      end
    end else if (en) begin
      // The step in the carry cycle still uses the old word.
      phase_d = sum_s[PHASE_W-1:0];
      start_d = sum_s[PHASE_W];
      if (sum_s[PHASE_W] && pend_q) begin
        fw_d   = fwp_q;
        pend_d = 1'b0;
      end else begin
        fw_d   = fw_q;
      end
    end else begin
      phase_d = phase_q;
    end
    // A transfer can only happen with the slot empty, so it never collides with an apply.
    if (accept_s) begin
      fwp_d  = fw_data;
      pend_d = 1'b1;
    end else begin
      fwp_d  = fwp_q;
    end
    rdy_d = ~pend_d;
  end

  // Register accumulator and handshake state.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      fw_q    <= FW_RESET;
      fwp_q   <= '0;
      pend_q  <= 1'b0;
      rdy_q   <= 1'b1;
      start_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      fw_q    <= fw_d;
      fwp_q   <= fwp_d;
      pend_q  <= pend_d;
      rdy_q   <= rdy_d;
      start_q <= start_d;
      step_q  <= step_d;
    end
  end

  // Quadrant fold, ROM read operand and output reconstruction.
  always_comb begin
    s1_quad_d = phase_q[PHASE_W-1 -: 2];
    idx_s     = phase_q[PHASE_W-3 -: Q_ADDR_W];
    s1_addr_d = s1_quad_d[0] ? ~idx_s : idx_s;
    s2_mag_d  = rom_s[s1_addr_q];
    dac_d     = s2_quad_q[1] ? (MID - {1'b0, s2_mag_q}) : (MID + {1'b0, s2_mag_q});
  end

  // Three-stage sample pipeline; always flows, flags travel with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_addr_q  <= '0;
      s1_quad_q  <= 2'd0;
      s1_start_q <= 1'b0;
      s1_vld_q   <= 1'b0;
      s2_mag_q   <= '0;
      s2_quad_q  <= 2'd0;
      s2_start_q <= 1'b0;
      s2_vld_q   <= 1'b0;
      dac_q      <= MID;
      car_vld_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      s1_addr_q  <= s1_addr_d;
      s1_quad_q  <= s1_quad_d;
      s1_start_q <= start_q;
      s1_vld_q   <= step_q;
      s2_mag_q   <= s2_mag_d;
      s2_quad_q  <= s1_quad_q;
      s2_start_q <= s1_start_q;
      s2_vld_q   <= s1_vld_q;
      dac_q      <= dac_d;
      car_vld_q  <= s2_vld_q;
      wrap_q     <= s2_start_q;
    end
  end

  assign fw_ready  = rdy_q;
  assign dac_car   = dac_q;
  assign car_valid = car_vld_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_dds_carrier.sv
// Self-checking bench for dds_carrier: a spec-level model predicts each phase
// value and pushes the expected sample into a scoreboard queue; samples are
// popped and compared when they emerge three edges later.

module tb_dds_carrier;

  localparam logic [31:0] FW_Q = 32'h4000_0000;   // quarter-cycle step
  localparam logic [31:0] FW_E = 32'h2000_0000;   // eighth-cycle step

  logic        clk = 1'b0;
  logic        rst, en, sync_clr, fw_valid;
  logic [31:0] fw_data;
  logic        fw_ready, car_valid, wrap;
  logic [11:0] dac_car;

  dds_carrier #(
    .PHASE_W (32),
    .Q_ADDR_W(10),
    .FW_RESET(FW_Q),
    .LUT_FILE("sine_q.hex")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .fw_data  (fw_data),
    .fw_valid (fw_valid),
    .fw_ready (fw_ready),
    .dac_car  (dac_car),
    .car_valid(car_valid),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] dac;
    logic        vld;
    logic        wrp;
    logic        care;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_wrap = 0;
  int          last_period = 0;
  logic [31:0] m_p, m_fw, m_fwp;
  logic        m_pend;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Ideal carrier sample for a phase value, straight from the sine definition.
  function automatic logic [11:0] exp_dac(input logic [31:0] p);
    logic [1:0] quad;
    logic [9:0] idx, a;
    real        ang;
    int         mag;
    quad = p[31:30];
    idx  = p[29:20];
    a    = quad[0] ? ~idx : idx;
    ang  = (2.0 * a + 1.0) * 3.14159265358979323846 / 4096.0;
    mag  = $rtoi(2047.0 * $sin(ang) + 0.5);
    return quad[1] ? 12'(2047 - mag) : 12'(2047 + mag);
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then check.
  task automatic tick();
    logic [32:0] s;
    logic        start, acc;
    exp_t        e;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_p = 32'd0; m_fw = FW_Q; m_fwp = 32'd0; m_pend = 1'b0;
      sb_q.delete();
      sb_q.push_back('{dac: 12'd0, vld: 1'b0, wrp: 1'b0, care: 1'b0});
      sb_q.push_back('{dac: 12'd0, vld: 1'b0, wrp: 1'b0, care: 1'b0});
      sb_q.push_back('{dac: exp_dac(32'd0), vld: 1'b0, wrp: 1'b0, care: 1'b1});
      check_val("rst_dac", dac_car, 32'd2047);
      check_val("rst_valid", car_valid, 32'd0);
      check_val("rst_wrap", wrap, 32'd0);
      check_val("rst_ready", fw_ready, 32'd1);
    end else begin
      acc   = fw_valid && !m_pend;
      start = 1'b0;
      if (sync_clr) begin
        m_p   = 32'd0;
        start = 1'b1;
        if (m_pend) begin m_fw = m_fwp; m_pend = 1'b0; end
      end else if (en) begin
        s     = {1'b0, m_p} + {1'b0, m_fw};
        m_p   = s[31:0];
        start = s[32];
        if (s[32] && m_pend) begin m_fw = m_fwp; m_pend = 1'b0; end
      end
      if (acc) begin m_fwp = fw_data; m_pend = 1'b1; end
      if (sb_q.size() == 0) begin
        check_val("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.care) check_val("dac", dac_car, e.dac);
        check_val("car_valid", car_valid, e.vld);
        check_val("wrap", wrap, e.wrp);
      end
      check_val("fw_ready", fw_ready, m_pend ? 32'd0 : 32'd1);
      sb_q.push_back('{dac: exp_dac(m_p), vld: en, wrp: start, care: 1'b1});
      if (wrap === 1'b1) begin
        last_period = cyc - last_wrap;
        last_wrap   = cyc;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          waited;
    logic [32:0] s;
    rst = 1'b1; en = 1'b1; sync_clr = 1'b0; fw_valid = 1'b0; fw_data = 32'd0;

    // Reset held with en=1, then release.
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tick();
    check_val("first_valid", car_valid, 32'd1);

    // Steady FW=2^30: 2049, 4094, 2045, 0 with wrap on 2049.
    waited = 0;
    while (wrap !== 1'b1 && waited < 8) begin tick(); waited++; end
    check_val("wrap_seen", wrap, 32'd1);
    check_val("seq0", dac_car, 32'd2049);
    tick(); check_val("seq1", dac_car, 32'd4094);
    tick(); check_val("seq2", dac_car, 32'd2045);
    tick(); check_val("seq3", dac_car, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check_val("period4", last_period, 32'd4);

    // Deferred update sent mid-cycle.
    waited = 0;
    while (m_p != FW_Q && waited < 8) begin tick(); waited++; end
    fw_valid = 1'b1; fw_data = FW_E;
    tick();
    fw_valid = 1'b0;
    check_val("defer_ready", fw_ready, 32'd0);
    for (int i = 0; i < 30; i++) tick();
    check_val("period8", last_period, 32'd8);

    // Transfer coincident with a carry waits a full extra cycle.
    waited = 0;
    s = {1'b0, m_p} + {1'b0, m_fw};
    while (!s[32] && waited < 16) begin
      tick(); waited++;
      s = {1'b0, m_p} + {1'b0, m_fw};
    end
    check_val("carry_found", s[32], 32'd1);
    fw_valid = 1'b1; fw_data = FW_Q;
    tick();
    fw_valid = 1'b0;
    waited = 0;
    while (fw_ready !== 1'b1 && waited < 40) begin tick(); waited++; end
    check_val("coinc_apply_lat", waited, 32'd8);
    for (int i = 0; i < 10; i++) tick();
    check_val("period4_again", last_period, 32'd4);

    // en low for 5 cycles mid-cycle.
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    en = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // sync_clr with a pending word.
    waited = 0;
    s = {1'b0, m_p} + {1'b0, m_fw};
    while (s[32] && waited < 8) begin
      tick(); waited++;
      s = {1'b0, m_p} + {1'b0, m_fw};
    end
    fw_valid = 1'b1; fw_data = FW_E;
    tick();
    fw_valid = 1'b0;
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    check_val("sclr_ready", fw_ready, 32'd1);
    tick(); tick(); tick();
    check_val("sclr_wrap", wrap, 32'd1);
    check_val("sclr_dac", dac_car, 32'd2049);
    for (int i = 0; i < 12; i++) tick();

    // Random traffic, a mid-run reset, then more random traffic.
    for (int i = 0; i < 300; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      sync_clr = ($urandom_range(0, 29) == 0);
      fw_valid = ($urandom_range(0, 5) == 0);
      fw_data  = $urandom;
      tick();
    end
    rst = 1'b1; fw_valid = 1'b1; fw_data = $urandom;
    tick();
    rst = 1'b0; fw_valid = 1'b0; sync_clr = 1'b0; en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      sync_clr = ($urandom_range(0, 19) == 0);
      fw_valid = ($urandom_range(0, 3) == 0);
      fw_data  = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
